// File: rtl/conf_int_mul__cfg_prec_pipe_pkg.sv
// Shared types and helpers for the configurable-precision multiplier.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, default widths, and the cut clamp helper.
package conf_int_mul_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_e;

  localparam int DEF_A_W     = 24;
  localparam int DEF_B_W     = 13;
  localparam int DEF_OUT_W   = 32;
  localparam int DEF_OUT_LSB = 8;
  localparam int DEF_CNT_W   = 16;

  // A cut of w or more would zero the whole operand; keep at least the sign bit.
  function automatic int f_clamp_cut(input int cut, input int w);
    return (cut >= w) ? (w - 1) : cut;
  endfunction

endpackage

// File: rtl/conf_int_mul__cfg_prec_pipe_if.sv
// Operand/result handshake bundle for the configurable-precision multiplier.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
// slave = multiplier view, master = operand source / result sink view.
interface conf_int_mul__cfg_prec_pipe_if #(
  parameter int A_W   = 24,
  parameter int B_W   = 13,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   A_in;
  logic [B_W-1:0]   B_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] P;
  logic             out_apx;

  modport slave (
    input  in_valid, A_in, B_in, out_ready,
    output in_ready, out_valid, P, out_apx
  );

  modport master (
    output in_valid, A_in, B_in, out_ready,
    input  in_ready, out_valid, P, out_apx
  );
endinterface

// File: rtl/conf_int_mul__mask_scale.sv
// Operand LSB masking plus signed multiply, arithmetic scale and optional clamp.
// Latency: 0 (combinational, sits between S1 and S2).
// Backpressure: none; the caller's pipeline registers handle stalls.
// Ports: a/b operands, apx + cut_a/cut_b masking control, p scaled product,
// sat (only with CONF_INT_MUL_CFG_PREC_SAT_EN) flags a clamped result.
module conf_int_mul__mask_scale
  import conf_int_mul_pkg::*;
#(
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int OUT_LSB = DEF_OUT_LSB,
  localparam int CA_W   = $clog2(A_W),
  localparam int CB_W   = $clog2(B_W)
) (
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             apx,
  input  logic [CA_W-1:0]  cut_a,
  input  logic [CB_W-1:0]  cut_b,
  output logic [OUT_W-1:0] p
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
  ,
  output logic             sat
`endif
);
  localparam int PW = A_W + B_W;
  // Working width is wide enough to hold the full product and any sign extension to OUT_W.
  localparam int EW = (PW > OUT_W) ? PW : OUT_W;
  localparam logic [A_W-1:0] ONES_A = '1;
  localparam logic [B_W-1:0] ONES_B = '1;

  logic signed [A_W-1:0] a_m;
  logic signed [B_W-1:0] b_m;
  logic signed [EW-1:0]  prod;

  always_comb begin
    a_m  = apx ? (a & (ONES_A << cut_a)) : a;
    b_m  = apx ? (b & (ONES_B << cut_b)) : b;
    prod = EW'(a_m) * EW'(b_m);
  end

`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
  logic signed [EW-1:0] sh;
  logic                 ovf;
  always_comb begin
    sh  = prod >>> OUT_LSB;
    // Fits in OUT_W signed only if every bit above the result sign matches it.
    ovf = (|sh[EW-1:OUT_W-1]) & ~(&sh[EW-1:OUT_W-1]);
    p   = ovf ? (sh[EW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
              : sh[OUT_W-1:0];
    sat = ovf;
  end
`else
  assign p = OUT_W'(prod >>> OUT_LSB);
`endif

endmodule

// File: rtl/conf_int_mul__cfg_prec_pipe.sv
// Two-stage signed fixed-point multiplier with runtime accurate/approximate precision.
// Latency: 2 cycles accept-to-out_valid, 1 result per cycle.
// Backpressure: out_ready low stalls S2 then S1; in_ready drops when both are full.
// Ports: clk/racc (async active-high reset), bus (operand/result handshake),
// cfg_req/cfg_acc/cfg_cut_a/cfg_cut_b/cfg_ack reconfiguration, state_out FSM state,
// cnt_clr/apx_cnt approximate-result counter, sat_flag (CONF_INT_MUL_CFG_PREC_SAT_EN only).
module conf_int_mul__cfg_prec_pipe
  import conf_int_mul_pkg::*;
#(
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int OUT_LSB = DEF_OUT_LSB,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int CA_W   = $clog2(A_W),
  localparam int CB_W   = $clog2(B_W)
) (
  input  logic                clk,
  input  logic                racc,
  conf_int_mul__cfg_prec_pipe_if.slave bus,
  input  logic                cfg_req,
  input  logic                cfg_acc,
  input  logic [CA_W-1:0]     cfg_cut_a,
  input  logic [CB_W-1:0]     cfg_cut_b,
  output logic                cfg_ack,
  output logic [1:0]          state_out,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    apx_cnt
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
  ,
  output logic                sat_flag
`endif
);
  state_e state, state_nx;

  logic            mode_acc;
  logic [CA_W-1:0] cut_a_r;
  logic [CB_W-1:0] cut_b_r;

  logic             s1_v, s1_apx;
  logic [A_W-1:0]   s1_a;
  logic [B_W-1:0]   s1_b;
  logic [CA_W-1:0]  s1_ca;
  logic [CB_W-1:0]  s1_cb;
  logic             s2_v, s2_apx;
  logic [OUT_W-1:0] s2_p;
  logic [OUT_W-1:0] ms_p;

  logic s2_load, s1_load, accept, out_hs;

  assign s2_load      = ~s2_v | bus.out_ready;
  assign s1_load      = ~s1_v | s2_load;
  // A pending cfg_req blocks new operands so the drain can complete.
  assign bus.in_ready = s1_load & (state == RUN) & ~cfg_req;
  assign accept       = bus.in_valid & bus.in_ready;
  assign out_hs       = s2_v & bus.out_ready;

  assign bus.out_valid = s2_v;
  assign bus.P         = s2_p;
  assign bus.out_apx   = s2_apx;
  assign state_out     = state;

  // S1 keeps raw operands plus the mode/cut snapshot taken at accept; masking is
  // applied in the S1->S2 combinational stage.
  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      s1_v   <= 1'b0;
      s1_apx <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_ca  <= '0;
      s1_cb  <= '0;
    end else if (s1_load) begin
      s1_v <= accept;
      if (accept) begin
        s1_apx <= ~mode_acc;
        s1_a   <= bus.A_in;
        s1_b   <= bus.B_in;
        s1_ca  <= cut_a_r;
        s1_cb  <= cut_b_r;
      end
    end
  end

`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
  logic ms_sat;
`endif

  conf_int_mul__mask_scale #(
    .A_W    (A_W),
    .B_W    (B_W),
    .OUT_W  (OUT_W),
    .OUT_LSB(OUT_LSB)
  ) u_mask_scale (
    .a    (s1_a),
    .b    (s1_b),
    .apx  (s1_apx),
    .cut_a(s1_ca),
    .cut_b(s1_cb),
    .p    (ms_p)
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
    ,
    .sat  (ms_sat)
`endif
  );

  // Output data only moves when a new result enters, so P/out_apx hold through stalls.
  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      s2_v     <= 1'b0;
      s2_apx   <= 1'b0;
      s2_p     <= '0;
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_apx   <= s1_apx;
        s2_p     <= ms_p;
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
        sat_flag <= ms_sat;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) state <= RUN;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cfg_ack  = 1'b0;
    case (state)
      RUN:     if (cfg_req) state_nx = DRAIN;
      DRAIN:   if (~s1_v & ~s2_v) state_nx = APPLY;
      APPLY: begin
        cfg_ack  = 1'b1;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      mode_acc <= 1'b1;
      cut_a_r  <= '0;
      cut_b_r  <= '0;
    end else if (state == APPLY) begin
      mode_acc <= cfg_acc;
      cut_a_r  <= CA_W'(f_clamp_cut(int'(cfg_cut_a), A_W));
      cut_b_r  <= CB_W'(f_clamp_cut(int'(cfg_cut_b), B_W));
    end
  end

  // Saturating profile counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge racc) begin
    if (racc)                             apx_cnt <= '0;
    else if (cnt_clr)                     apx_cnt <= '0;
    else if (out_hs & s2_apx & ~&apx_cnt) apx_cnt <= apx_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_conf_int_mul__cfg_prec_pipe.sv
// Directed bench for the configurable-precision multiplier (default and OUT_W=16 instances).
// Latency: checks the 2-cycle accept-to-result timing and 2-cycle reconfiguration.
// Backpressure: exercises out_ready stalls, drain-before-reconfigure and async reset.
module tb_conf_int_mul__cfg_prec_pipe;
  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- default instance ----------------
  conf_int_mul__cfg_prec_pipe_if #(.A_W(24), .B_W(13), .OUT_W(32)) bus0 ();
  logic        cfg_req, cfg_acc, cfg_ack, cnt_clr;
  logic [4:0]  cfg_cut_a;
  logic [3:0]  cfg_cut_b;
  logic [1:0]  state_out;
  logic [15:0] apx_cnt;

  // ---------------- OUT_W=16, CNT_W=2 instance ----------------
  conf_int_mul__cfg_prec_pipe_if #(.A_W(24), .B_W(13), .OUT_W(16)) bus1 ();
  logic        cfg_req1, cfg_acc1, cfg_ack1, cnt_clr1;
  logic [4:0]  cfg_cut_a1;
  logic [3:0]  cfg_cut_b1;
  logic [1:0]  state_out1;
  logic [1:0]  apx_cnt1;

`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
  logic sat_flag, sat_flag1;
`endif

  conf_int_mul__cfg_prec_pipe u0 (
    .clk(clk), .racc(rst), .bus(bus0),
    .cfg_req(cfg_req), .cfg_acc(cfg_acc), .cfg_cut_a(cfg_cut_a), .cfg_cut_b(cfg_cut_b),
    .cfg_ack(cfg_ack), .state_out(state_out), .cnt_clr(cnt_clr), .apx_cnt(apx_cnt)
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  conf_int_mul__cfg_prec_pipe #(.OUT_W(16), .CNT_W(2)) u1 (
    .clk(clk), .racc(rst), .bus(bus1),
    .cfg_req(cfg_req1), .cfg_acc(cfg_acc1), .cfg_cut_a(cfg_cut_a1), .cfg_cut_b(cfg_cut_b1),
    .cfg_ack(cfg_ack1), .state_out(state_out1), .cnt_clr(cnt_clr1), .apx_cnt(apx_cnt1)
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
    , .sat_flag(sat_flag1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reconfigure u0 with an empty pipeline; an operand is offered throughout to show cfg_req wins.
  task automatic do_cfg(input logic acc, input logic [4:0] ca, input logic [3:0] cb);
    cfg_req = 1'b1; cfg_acc = acc; cfg_cut_a = ca; cfg_cut_b = cb;
    bus0.in_valid = 1'b1; bus0.A_in = 24'h000123; bus0.B_in = 13'h0002;
    #1 chk("cfg_inrdy", 64'(bus0.in_ready), 64'd0);
    tick();
    chk("cfg_drain", 64'(state_out), 64'd1);
    chk("cfg_noack", 64'(cfg_ack), 64'd0);
    tick();
    chk("cfg_apply", 64'(state_out), 64'd2);
    chk("cfg_ack", 64'(cfg_ack), 64'd1);
    chk("cfg_noout", 64'(bus0.out_valid), 64'd0);
    tick();
    chk("cfg_run", 64'(state_out), 64'd0);
    chk("cfg_ack_lo", 64'(cfg_ack), 64'd0);
    cfg_req = 1'b0;
    bus0.in_valid = 1'b0;
  endtask

  // Single operation on u0 with out_ready high: result must appear exactly 2 cycles after accept.
  task automatic op(input string tag, input logic [23:0] a, input logic [12:0] b,
                    input logic [31:0] ep, input logic eapx);
    bus0.in_valid = 1'b1; bus0.A_in = a; bus0.B_in = b;
    #1 chk({tag, "_inrdy"}, 64'(bus0.in_ready), 64'd1);
    tick();
    bus0.in_valid = 1'b0;
    chk({tag, "_v1"}, 64'(bus0.out_valid), 64'd0);
    tick();
    chk({tag, "_v2"}, 64'(bus0.out_valid), 64'd1);
    chk({tag, "_p"}, 64'(bus0.P), 64'(ep));
    chk({tag, "_apx"}, 64'(bus0.out_apx), 64'(eapx));
    tick();
  endtask

  logic [23:0] s_a  [4];
  logic [31:0] s_exp[4];

  initial begin
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.A_in = '0; bus0.B_in = '0; bus0.out_ready = 1'b1;
    cfg_req = 1'b0; cfg_acc = 1'b1; cfg_cut_a = '0; cfg_cut_b = '0; cnt_clr = 1'b0;
    bus1.in_valid = 1'b0; bus1.A_in = '0; bus1.B_in = '0; bus1.out_ready = 1'b1;
    cfg_req1 = 1'b0; cfg_acc1 = 1'b1; cfg_cut_a1 = '0; cfg_cut_b1 = '0; cnt_clr1 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_p", 64'(bus0.P), 64'd0);
    chk("rst_apx", 64'(bus0.out_apx), 64'd0);
    chk("rst_ack", 64'(cfg_ack), 64'd0);
    chk("rst_cnt", 64'(apx_cnt), 64'd0);
    chk("rst_state", 64'(state_out), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_inrdy", 64'(bus0.in_ready), 64'd1);

    // Accurate default: 256*3 >> 8 = 3
    op("acc", 24'h000100, 13'h0003, 32'd3, 1'b0);

    // Approximate cut_a=8: 0x1FF -> 0x100, *3 >> 8 = 3
    do_cfg(1'b0, 5'd8, 4'd0);
    op("apx", 24'h0001FF, 13'h0003, 32'd3, 1'b1);
    chk("apx_cnt1", 64'(apx_cnt), 64'd1);

    // Accurate again: 0x1FF*3 = 0x5FD >> 8 = 5
    do_cfg(1'b1, 5'd0, 4'd0);
    op("acc5", 24'h0001FF, 13'h0003, 32'd5, 1'b0);

    // Signed: (-256)*(-1) >> 8 = 1
    op("sgn", 24'hFFFF00, 13'h1FFF, 32'd1, 1'b0);

    // cut_a 31 clamps to 23: -1 -> -2^23, >> 8 = -32768
    do_cfg(1'b0, 5'd31, 4'd0);
    op("clampa", 24'hFFFFFF, 13'h0001, 32'hFFFF8000, 1'b1);

    // cut_b=2: 7 -> 4, 256*4 >> 8 = 4
    do_cfg(1'b0, 5'd0, 4'd2);
    op("cutb", 24'h000100, 13'h0007, 32'd4, 1'b1);

    // cut_b 15 clamps to 12: -1 -> -4096, *256 >> 8 = -4096
    do_cfg(1'b0, 5'd0, 4'd15);
    op("clampb", 24'h000100, 13'h1FFF, 32'hFFFFF000, 1'b1);

    // Stream of 4 with out_ready low for cycles 2..4
    do_cfg(1'b1, 5'd0, 4'd0);
    s_a[0] = 24'h000100; s_a[1] = 24'h000200; s_a[2] = 24'h000300; s_a[3] = 24'h000400;
    s_exp[0] = 32'd5; s_exp[1] = 32'd10; s_exp[2] = 32'd15; s_exp[3] = 32'd20;
    begin
      int sent = 0;
      int rcv  = 0;
      for (int c = 0; c < 30 && rcv < 4; c++) begin
        bus0.in_valid = (sent < 4);
        bus0.A_in = s_a[(sent < 4) ? sent : 3];
        bus0.B_in = 13'd5;
        bus0.out_ready = !(c >= 2 && c <= 4);
        #1;
        if (c == 2) chk("str_full_inrdy", 64'(bus0.in_ready), 64'd0);
        if (bus0.out_valid && rcv < 4) chk("str_p", 64'(bus0.P), 64'(s_exp[rcv]));
        if (bus0.out_valid && bus0.out_ready) rcv++;
        if (bus0.in_valid && bus0.in_ready) sent++;
        tick();
      end
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      chk("str_rcv", 64'(rcv), 64'd4);
      chk("str_sent", 64'(sent), 64'd4);
      tick();
      chk("str_nodup", 64'(bus0.out_valid), 64'd0);
    end

    // Drain: two approximate ops stalled, then switch to accurate
    do_cfg(1'b0, 5'd8, 4'd0);
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.A_in = 24'h0001FF; bus0.B_in = 13'h0003;
    tick();
    bus0.A_in = 24'h0002FF;
    tick();
    bus0.in_valid = 1'b0;
    cfg_req = 1'b1; cfg_acc = 1'b1; cfg_cut_a = '0; cfg_cut_b = '0;
    #1 chk("drn_inrdy", 64'(bus0.in_ready), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("drn_state", 64'(state_out), 64'd1);
      chk("drn_p0", 64'(bus0.P), 64'd3);
      chk("drn_apx0", 64'(bus0.out_apx), 64'd1);
      tick();
    end
    bus0.out_ready = 1'b1;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("drn_clr_prio", 64'(apx_cnt), 64'd0);
    chk("drn_state2", 64'(state_out), 64'd1);
    chk("drn_p1", 64'(bus0.P), 64'd6);
    chk("drn_apx1", 64'(bus0.out_apx), 64'd1);
    tick();
    chk("drn_cnt", 64'(apx_cnt), 64'd1);
    chk("drn_state3", 64'(state_out), 64'd1);
    chk("drn_empty", 64'(bus0.out_valid), 64'd0);
    tick();
    chk("drn_apply", 64'(state_out), 64'd2);
    chk("drn_ack", 64'(cfg_ack), 64'd1);
    tick();
    chk("drn_run", 64'(state_out), 64'd0);
    chk("drn_ack_lo", 64'(cfg_ack), 64'd0);
    cfg_req = 1'b0;
    op("drn_acc", 24'h0001FF, 13'h0003, 32'd5, 1'b0);

    // OUT_W=16 instance: (2^23-1)*(2^12-1) >> 8 overflows 16 bits
    bus1.in_valid = 1'b1; bus1.A_in = 24'h7FFFFF; bus1.B_in = 13'h0FFF;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    chk("w16_valid", 64'(bus1.out_valid), 64'd1);
`ifdef CONF_INT_MUL_CFG_PREC_SAT_EN
    chk("w16_p_sat", 64'(bus1.P), 64'h7FFF);
    chk("w16_satflag", 64'(sat_flag1), 64'd1);
`else
    chk("w16_p_wrap", 64'(bus1.P), 64'h7FF0);
`endif
    tick();

    // 2-bit counter saturates at 3 after 4 approximate results
    cfg_req1 = 1'b1; cfg_acc1 = 1'b0;
    tick();
    tick();
    chk("w16_ack", 64'(cfg_ack1), 64'd1);
    tick();
    cfg_req1 = 1'b0;
    bus1.in_valid = 1'b1; bus1.A_in = 24'h000001; bus1.B_in = 13'h0001;
    repeat (4) tick();
    bus1.in_valid = 1'b0;
    repeat (3) tick();
    chk("w16_cnt_sat", 64'(apx_cnt1), 64'd3);

    // Async reset in the middle of a DRAIN with results in flight
    do_cfg(1'b0, 5'd8, 4'd0);
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.A_in = 24'h0001FF; bus0.B_in = 13'h0003;
    tick();
    tick();
    bus0.in_valid = 1'b0;
    cfg_req = 1'b1; cfg_acc = 1'b0;
    tick();
    chk("rd_drain", 64'(state_out), 64'd1);
    chk("rd_cnt_pre", 64'(apx_cnt), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rd_valid", 64'(bus0.out_valid), 64'd0);
    chk("rd_state", 64'(state_out), 64'd0);
    chk("rd_cnt", 64'(apx_cnt), 64'd0);
    chk("rd_ack", 64'(cfg_ack), 64'd0);
    cfg_req = 1'b0;
    bus0.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rd_noout", 64'(bus0.out_valid), 64'd0);
    op("rd_acc", 24'h0001FF, 13'h0003, 32'd5, 1'b0);
    chk("rd_cnt_post", 64'(apx_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
